// File: rtl/pcmon_pkg.sv
// Shared types for the PC trace monitor.
// State encoding, trace entry layout and default widths.
package pcmon_pkg;
  localparam int CNT_W_DEF = 32;
  localparam int PC_W_DEF  = 32;
  localparam int ENTRY_W_DEF = CNT_W_DEF + PC_W_DEF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STALLED,
    DONE
  } state_e;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] cycle;
    logic [PC_W_DEF-1:0]  pc;
  } trace_t;
endpackage

// File: rtl/pcmon_if.sv
// Trace FIFO read port of the PC trace monitor.
// master = reader side, slave = monitor side.
interface pcmon_if
  import pcmon_pkg::*;
#(
  parameter int W = ENTRY_W_DEF
);
  logic         trace_rd_en;
  logic [W-1:0] trace_rd_data;
  logic         trace_empty;
  logic         trace_full;
  logic         trace_ovf;

  modport master (
    output trace_rd_en,
    input  trace_rd_data,
    input  trace_empty,
    input  trace_full,
    input  trace_ovf
  );

  modport slave (
    input  trace_rd_en,
    output trace_rd_data,
    output trace_empty,
    output trace_full,
    output trace_ovf
  );
endinterface

// File: rtl/pcmon_trace_fifo.sv
// Show-ahead synchronous trace FIFO with sticky overflow.
// A write while full is dropped unless a read frees the slot.
module pcmon_trace_fifo
  import pcmon_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = ENTRY_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             wr_ok, rd_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign ovf     = ovf_q;

  // Accept logic: a read in the same cycle makes room for a write.
  always_comb begin
    rd_ok    = rd_en && !empty;
    wr_ok    = wr_en && (!full || rd_ok);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_ok};
    ovf_d    = ovf_q | (wr_en && !wr_ok);
  end

  // Pointer and overflow state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage; cleared so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end
endmodule

// File: rtl/pc_trace_monitor.sv
// Run monitor: cycle/retire counters, periodic PC trace, stall and budget.
// Optional PCMON_DISPLAY_EN prints each sample in simulation.
module pc_trace_monitor
  import pcmon_pkg::*;
#(
  parameter int CNT_W           = CNT_W_DEF,
  parameter int PC_W            = PC_W_DEF,
  parameter int SAMPLE_INTERVAL = 100,
  parameter int TRACE_DEPTH     = 16,
  parameter int STALL_LIMIT     = 64,
  parameter int MAX_CYCLES      = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_en,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             pc_valid,
  pcmon_if.slave           trace,
  output logic             sample_pulse,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count,
  output logic             stall_flag,
  output logic             done
);
  localparam int IW = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [IW-1:0]    INT_LAST = IW'(SAMPLE_INTERVAL - 1);
  localparam logic [SW-1:0]    STL_MAX  = SW'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] BUDGET   = CNT_W'(MAX_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [IW-1:0]    int_q, int_d;
  logic [SW-1:0]    stl_q, stl_d;
  logic [PC_W-1:0]  prev_pc_q, prev_pc_d;
  logic             pulse_q, pulse_d;
  logic             done_q, done_d;
  logic             stall_q, stall_d;
  logic             count_en, pc_chg, sample, budget_hit;

  // Counters, interval, stall tracking and next state.
  always_comb begin
    cycle_d    = cycle_q;
    retire_d   = retire_q;
    int_d      = int_q;
    stl_d      = stl_q;
    prev_pc_d  = prev_pc_q;
    state_d    = state_q;
    sample     = 1'b0;
    budget_hit = 1'b0;
    count_en   = run_en && (state_q != DONE);
    pc_chg     = (pc_in != prev_pc_q);
    if (count_en) begin
      if (!(&cycle_q)) cycle_d = cycle_q + 1'b1;
      if (pc_valid && !(&retire_q)) retire_d = retire_q + 1'b1;
      if (int_q == INT_LAST) begin
        int_d  = '0;
        sample = 1'b1;
      end else begin
        int_d = int_q + 1'b1;
      end
      prev_pc_d = pc_in;
      if (pc_chg) stl_d = '0;
      else if (stl_q != STL_MAX) stl_d = stl_q + 1'b1;
      budget_hit = (MAX_CYCLES != 0) && (cycle_d == BUDGET);
    end
    unique case (state_q)
      IDLE: begin
        if (run_en) state_d = budget_hit ? DONE : RUN;
      end
      RUN: begin
        if (!run_en) state_d = IDLE;
        else if (budget_hit) state_d = DONE;
        else if (stl_d == STL_MAX) state_d = STALLED;
      end
      STALLED: begin
        if (!run_en) state_d = IDLE;
        else if (budget_hit) state_d = DONE;
        else if (pc_chg) state_d = RUN;
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
    pulse_d = sample;
    done_d  = (state_d == DONE);
    stall_d = (state_d == STALLED);
  end

  // FSM, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cycle_q   <= '0;
      retire_q  <= '0;
      int_q     <= '0;
      stl_q     <= '0;
      prev_pc_q <= '0;
      pulse_q   <= 1'b0;
      done_q    <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      retire_q  <= retire_d;
      int_q     <= int_d;
      stl_q     <= stl_d;
      prev_pc_q <= prev_pc_d;
      pulse_q   <= pulse_d;
      done_q    <= done_d;
      stall_q   <= stall_d;
    end
  end

  assign sample_pulse = pulse_q;
  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;
  assign stall_flag   = stall_q;
  assign done         = done_q;

  pcmon_trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (CNT_W + PC_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (sample),
    .wr_data ({cycle_d, pc_in}),
    .rd_en   (trace.trace_rd_en),
    .rd_data (trace.trace_rd_data),
    .empty   (trace.trace_empty),
    .full    (trace.trace_full),
    .ovf     (trace.trace_ovf)
  );

`ifdef PCMON_DISPLAY_EN
`ifndef SYNTHESIS
  // Simulation echo of every sample.
  always_ff @(posedge clk) begin
    if (sample)
      $display("Time: %0t ns, Cycle: %0d, PC: %h", $time, cycle_d, pc_in);
  end
`endif
`else
  // Hardware-only build: samples go to the FIFO alone.
`endif
endmodule

// File: tb/tb_pc_trace_monitor.sv
// Directed bench for pc_trace_monitor.
// Default instance plus a shallow, every-cycle-sampling instance.
module tb_pc_trace_monitor;
  import pcmon_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_en0 = 1'b0, pc_valid0 = 1'b0;
  logic [31:0] pc0 = '0;
  logic        run_en1 = 1'b0, pc_valid1 = 1'b0;
  logic [31:0] pc1 = '0;
  logic        sp0, st0, dn0, sp1, st1, dn1;
  logic [31:0] cc0, rc0, cc1, rc1;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp;
  int          npulse;

  pcmon_if #(.W(64)) tif0 ();
  pcmon_if #(.W(64)) tif1 ();

  always #5 clk = ~clk;

  pc_trace_monitor u0 (
    .clk(clk), .rst_n(rst_n), .run_en(run_en0), .pc_in(pc0),
    .pc_valid(pc_valid0), .trace(tif0.slave), .sample_pulse(sp0),
    .cycle_count(cc0), .retire_count(rc0), .stall_flag(st0), .done(dn0)
  );

  pc_trace_monitor #(
    .SAMPLE_INTERVAL(1), .TRACE_DEPTH(4), .MAX_CYCLES(0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .run_en(run_en1), .pc_in(pc1),
    .pc_valid(pc_valid1), .trace(tif1.slave), .sample_pulse(sp1),
    .cycle_count(cc1), .retire_count(rc1), .stall_flag(st1), .done(dn1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run_en0 = 0; pc_valid0 = 0; pc0 = '0; tif0.trace_rd_en = 0;
    run_en1 = 0; pc_valid1 = 0; pc1 = '0; tif1.trace_rd_en = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cc0 !== 0) begin errors++; $display("FAIL rst_cycle: got %0d exp 0", cc0); end
    checks++; if (tif0.trace_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b exp 1", tif0.trace_empty); end
    checks++; if (dn0 !== 1'b0) begin errors++; $display("FAIL rst_done: got %b exp 0", dn0); end
    run_en0 = 1; pc_valid0 = 1;
    for (int i = 0; i < 10; i++) begin pc0 = 32'h100 + 4 * i; tick(); end
    checks++; if (cc0 !== 10) begin errors++; $display("FAIL pre_async_cycle: got %0d exp 10", cc0); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (cc0 !== 0 || rc0 !== 0) begin errors++; $display("FAIL async_counts: got %0d/%0d exp 0/0", cc0, rc0); end
    checks++; if (tif0.trace_empty !== 1'b1 || dn0 !== 1'b0 || st0 !== 1'b0) begin errors++; $display("FAIL async_flags: got e%b d%b s%b exp e1 d0 s0", tif0.trace_empty, dn0, st0); end
    do_reset();
  endtask

  task automatic test_run();
    do_reset();
    npulse = 0;
    run_en0 = 1; pc_valid0 = 1;
    for (int i = 0; i < 250; i++) begin
      pc0 = 32'h1000 + 4 * i;
      tick();
      if (sp0 === 1'b1) begin
        npulse++;
        checks++; if ((cc0 % 100) != 0) begin errors++; $display("FAIL pulse_cycle: got %0d exp multiple of 100", cc0); end
      end
    end
    run_en0 = 0;
    checks++; if (cc0 !== 250 || rc0 !== 250) begin errors++; $display("FAIL run_counts: got %0d/%0d exp 250/250", cc0, rc0); end
    checks++; if (npulse !== 2) begin errors++; $display("FAIL run_pulses: got %0d exp 2", npulse); end
    tick();
    exp = {32'd100, 32'h1000 + 32'd396};
    checks++; if (tif0.trace_rd_data !== exp) begin errors++; $display("FAIL run_entry0: got %h exp %h", tif0.trace_rd_data, exp); end
    tif0.trace_rd_en = 1; tick(); tif0.trace_rd_en = 0;
    exp = {32'd200, 32'h1000 + 32'd796};
    checks++; if (tif0.trace_rd_data !== exp) begin errors++; $display("FAIL run_entry1: got %h exp %h", tif0.trace_rd_data, exp); end
    tif0.trace_rd_en = 1; tick(); tif0.trace_rd_en = 0;
    checks++; if (tif0.trace_empty !== 1'b1) begin errors++; $display("FAIL run_drained: got %b exp 1", tif0.trace_empty); end
  endtask

  task automatic test_stall();
    do_reset();
    run_en0 = 1; pc_valid0 = 0; pc0 = 32'h2000;
    tick();
    for (int i = 0; i < 63; i++) tick();
    checks++; if (st0 !== 1'b0 || cc0 !== 64) begin errors++; $display("FAIL stall_63: got s%b c%0d exp s0 c64", st0, cc0); end
    tick();
    checks++; if (st0 !== 1'b1) begin errors++; $display("FAIL stall_64: got %b exp 1", st0); end
    tick(); tick(); tick();
    checks++; if (st0 !== 1'b1) begin errors++; $display("FAIL stall_hold: got %b exp 1", st0); end
    pc0 = 32'h2004;
    tick();
    checks++; if (st0 !== 1'b0) begin errors++; $display("FAIL stall_clear: got %b exp 0", st0); end
    checks++; if (rc0 !== 0) begin errors++; $display("FAIL stall_retire: got %0d exp 0", rc0); end
    run_en0 = 0;
  endtask

  task automatic test_overflow();
    do_reset();
    run_en1 = 1; pc_valid1 = 1;
    for (int k = 1; k <= 6; k++) begin
      pc1 = 32'h3000 + 4 * k;
      tick();
      if (k == 1) begin
        checks++; if (tif1.trace_empty !== 1'b0) begin errors++; $display("FAIL ovf_not_empty: got %b exp 0", tif1.trace_empty); end
      end
      if (k == 4) begin
        checks++; if (tif1.trace_full !== 1'b1 || tif1.trace_ovf !== 1'b0) begin errors++; $display("FAIL ovf_full4: got f%b o%b exp f1 o0", tif1.trace_full, tif1.trace_ovf); end
      end
      if (k == 5) begin
        checks++; if (tif1.trace_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b exp 1", tif1.trace_ovf); end
      end
    end
    exp = {32'd1, 32'h3004};
    checks++; if (tif1.trace_rd_data !== exp) begin errors++; $display("FAIL ovf_head: got %h exp %h", tif1.trace_rd_data, exp); end
    pc1 = 32'h3000 + 4 * 7;
    tif1.trace_rd_en = 1;
    tick();
    run_en1 = 0; tif1.trace_rd_en = 0;
    checks++; if (tif1.trace_full !== 1'b1) begin errors++; $display("FAIL ovf_rw_full: got %b exp 1", tif1.trace_full); end
    tick();
    for (int j = 0; j < 4; j++) begin
      int c;
      c = (j < 3) ? j + 2 : 7;
      exp = {32'(c), 32'h3000 + 32'(4 * c)};
      checks++; if (tif1.trace_rd_data !== exp) begin errors++; $display("FAIL ovf_entry%0d: got %h exp %h", j, tif1.trace_rd_data, exp); end
      tif1.trace_rd_en = 1; tick(); tif1.trace_rd_en = 0;
    end
    checks++; if (tif1.trace_empty !== 1'b1) begin errors++; $display("FAIL ovf_drained: got %b exp 1", tif1.trace_empty); end
    tif1.trace_rd_en = 1; tick(); tif1.trace_rd_en = 0;
    checks++; if (tif1.trace_empty !== 1'b1 || tif1.trace_ovf !== 1'b1) begin errors++; $display("FAIL ovf_empty_rd: got e%b o%b exp e1 o1", tif1.trace_empty, tif1.trace_ovf); end
    do_reset();
    checks++; if (tif1.trace_ovf !== 1'b0) begin errors++; $display("FAIL ovf_reset: got %b exp 0", tif1.trace_ovf); end
  endtask

  task automatic test_done();
    do_reset();
    run_en0 = 1; pc_valid0 = 1;
    for (int i = 0; i < 500; i++) begin
      pc0 = 32'h4000 + 4 * i;
      tick();
      if (i == 498) begin
        checks++; if (dn0 !== 1'b0) begin errors++; $display("FAIL done_early: got %b exp 0", dn0); end
      end
    end
    checks++; if (dn0 !== 1'b1 || cc0 !== 500) begin errors++; $display("FAIL done_set: got d%b c%0d exp d1 c500", dn0, cc0); end
    for (int i = 500; i < 550; i++) begin pc0 = 32'h4000 + 4 * i; tick(); end
    checks++; if (cc0 !== 500 || rc0 !== 500) begin errors++; $display("FAIL done_frozen: got %0d/%0d exp 500/500", cc0, rc0); end
    for (int j = 1; j <= 5; j++) begin
      exp = {32'(100 * j), 32'h4000 + 32'(4 * (100 * j - 1))};
      checks++; if (tif0.trace_rd_data !== exp) begin errors++; $display("FAIL done_entry%0d: got %h exp %h", j, tif0.trace_rd_data, exp); end
      tif0.trace_rd_en = 1; tick(); tif0.trace_rd_en = 0;
    end
    checks++; if (tif0.trace_empty !== 1'b1 || dn0 !== 1'b1) begin errors++; $display("FAIL done_drained: got e%b d%b exp e1 d1", tif0.trace_empty, dn0); end
  endtask

  task automatic test_pause();
    do_reset();
    pc_valid0 = 1;
    for (int i = 0; i < 350; i++) begin
      run_en0 = (i < 150 || i >= 300);
      pc0 = 32'h5000 + 4 * i;
      tick();
      if (i == 299) begin
        checks++; if (cc0 !== 150) begin errors++; $display("FAIL pause_hold: got %0d exp 150", cc0); end
      end
    end
    run_en0 = 0;
    checks++; if (cc0 !== 200 || rc0 !== 200) begin errors++; $display("FAIL pause_counts: got %0d/%0d exp 200/200", cc0, rc0); end
    tick();
    exp = {32'd100, 32'h5000 + 32'd396};
    checks++; if (tif0.trace_rd_data !== exp) begin errors++; $display("FAIL pause_entry0: got %h exp %h", tif0.trace_rd_data, exp); end
    tif0.trace_rd_en = 1; tick(); tif0.trace_rd_en = 0;
    exp = {32'd200, 32'h5000 + 32'd1396};
    checks++; if (tif0.trace_rd_data !== exp) begin errors++; $display("FAIL pause_entry1: got %h exp %h", tif0.trace_rd_data, exp); end
    tif0.trace_rd_en = 1; tick(); tif0.trace_rd_en = 0;
    checks++; if (tif0.trace_empty !== 1'b1) begin errors++; $display("FAIL pause_no_gap: got %b exp 1", tif0.trace_empty); end
  endtask

  initial begin
    tif0.trace_rd_en = 1'b0;
    tif1.trace_rd_en = 1'b0;
    test_reset();
    test_run();
    test_stall();
    test_overflow();
    test_done();
    test_pause();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
